// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared definitions for the pattern_gen_stream block.
//   - MODE_* : pattern select encodings for the 3-bit mode input
//   - state_t: stream FSM state encoding
//   - lfsr32_next(): one step of the 32-bit pattern LFSR
package pattern_gen_pkg;

   localparam logic [2:0] MODE_COUNTER  = 3'b000;
   localparam logic [2:0] MODE_LFSR     = 3'b001;
   localparam logic [2:0] MODE_WALK1    = 3'b010;
   localparam logic [2:0] MODE_WALK0    = 3'b011;
   localparam logic [2:0] MODE_HAMMER   = 3'b100;
   localparam logic [2:0] MODE_NEIGHBOR = 3'b101;
   localparam logic [2:0] MODE_CONST    = 3'b110;
   localparam logic [2:0] MODE_RSVD     = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1]};
   endfunction

endpackage

// File: rtl/pattern_gen_core.sv
// pattern_gen_core: pattern state registers and word generation.
//   clk, reset : clock, asynchronous active-high reset
//   load       : latch mode/seed and set up word 0
//   advance    : step every pattern generator to the next word
//   mode, seed : pattern select and seed, sampled on load
//   word       : current pattern word (combinational from registers only)
// All generators step together on advance; the latched mode just picks
// which one drives word.
module pattern_gen_core
   import pattern_gen_pkg::*;
#(
   parameter int          WIDTH      = 64,
   parameter logic [31:0] LFSR_RESET = 32'h04030201
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             advance,
   input  logic [2:0]       mode,
   input  logic [31:0]      seed,
   output logic [WIDTH-1:0] word
);

   localparam int LANES = WIDTH / 32;
   localparam int PW    = $clog2(WIDTH);

   logic [2:0]       mode_q;
   logic [31:0]      seed_q;
   logic [WIDTH-1:0] cnt_q;
   logic [31:0]      lfsr_q;
   logic [WIDTH-1:0] walk_q;
   logic             phase_q;   // 0 on even words, 1 on odd words
   logic [PW-1:0]    pos_q;     // neighbor-mode cleared bit position

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q  <= MODE_RSVD;
         seed_q  <= '0;
         cnt_q   <= '0;
         lfsr_q  <= '0;
         walk_q  <= '0;
         phase_q <= 1'b0;
         pos_q   <= '0;
      end else if (load) begin
         mode_q  <= mode;
         seed_q  <= seed;
         cnt_q   <= WIDTH'(seed);
         lfsr_q  <= (seed == 32'd0) ? LFSR_RESET : seed;
         walk_q  <= WIDTH'(1);
         phase_q <= 1'b0;
         pos_q   <= '0;
      end else if (advance) begin
         cnt_q   <= cnt_q + WIDTH'(1);
         lfsr_q  <= lfsr32_next(lfsr_q);
         walk_q  <= {walk_q[WIDTH-2:0], walk_q[WIDTH-1]};
         phase_q <= ~phase_q;
         // position moves on only after the odd (all-zero) word
         if (phase_q)
            pos_q <= (pos_q == PW'(WIDTH - 1)) ? '0 : pos_q + PW'(1);
      end
   end

   always_comb begin
      word = '0;
      case (mode_q)
         MODE_COUNTER:  word = cnt_q;
         MODE_LFSR:     word = {LANES{lfsr_q}};
         MODE_WALK1:    word = walk_q;
         MODE_WALK0:    word = ~walk_q;
         MODE_HAMMER:   word = phase_q ? '0 : '1;
         MODE_NEIGHBOR: word = phase_q ? '0 : ~(WIDTH'(1) << pos_q);
         MODE_CONST:    word = {LANES{seed_q}};
         default:       word = '0;
      endcase
   end

endmodule

// File: rtl/pattern_gen_stream.sv
// pattern_gen_stream: bus-test pattern source on a valid/ready stream.
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : 1-cycle control pulses
//   mode, seed, len     : burst configuration, latched on start (len 0 = continuous)
//   dout, dout_valid    : output word and valid
//   dout_ready          : sink ready; a word is accepted on valid & ready
//   busy                : burst in progress
//   done                : 1-cycle pulse, the cycle after the last accept or abort
//   word_cnt            : words accepted in the current/last burst
// Optional (PATTERN_GEN_ERR_INJECT_EN defined):
//   inj_arm, inj_index  : arm a single bit-0 flip on word inj_index of the next burst
//   inj_done            : 1-cycle pulse after the corrupted word is accepted
// dout_valid is a register-derived signal, so ready never feeds valid.
module pattern_gen_stream
   import pattern_gen_pkg::*;
#(
   parameter int          WIDTH      = 64,
   parameter int          LEN_W      = 32,
   parameter logic [31:0] LFSR_RESET = 32'h04030201
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [2:0]       mode,
   input  logic [31:0]      seed,
   input  logic [LEN_W-1:0] len,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] word_cnt
`ifdef PATTERN_GEN_ERR_INJECT_EN
   ,
   input  logic             inj_arm,
   input  logic [LEN_W-1:0] inj_index,
   output logic             inj_done
`endif
);

   state_t           state_q, state_d;
   logic             load, advance, finish, accept;
   logic [LEN_W-1:0] cnt_inc, len_q;
   logic             done_q;
   logic [WIDTH-1:0] word, inj_mask;

   assign accept  = (state_q == ST_RUN) && dout_ready;
   assign cnt_inc = word_cnt + LEN_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      finish  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               load    = 1'b1;
            end
         end
         ST_RUN: begin
            advance = accept;
            // a coincident accept still counts before the abort takes effect
            if (abort || (accept && len_q != '0 && cnt_inc == len_q)) begin
               state_d = ST_IDLE;
               finish  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= finish;
         if (load) begin
            word_cnt <= '0;
            len_q    <= len;
         end else if (advance) begin
            word_cnt <= cnt_inc;
         end
      end
   end

   pattern_gen_core #(
      .WIDTH      (WIDTH),
      .LFSR_RESET (LFSR_RESET)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .mode    (mode),
      .seed    (seed),
      .word    (word)
   );

`ifdef PATTERN_GEN_ERR_INJECT_EN
   logic             armed_q, pend_q, inj_done_q, hit;
   logic [LEN_W-1:0] idx_q;

   // pend_q clears after the first hit so a wrapping word_cnt cannot re-hit
   assign hit      = pend_q && (word_cnt == idx_q) && (state_q == ST_RUN);
   assign inj_mask = {{(WIDTH-1){1'b0}}, hit};
   assign inj_done = inj_done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed_q    <= 1'b0;
         pend_q     <= 1'b0;
         inj_done_q <= 1'b0;
         idx_q      <= '0;
      end else begin
         inj_done_q <= 1'b0;
         if (load) begin
            pend_q  <= armed_q | inj_arm;
            idx_q   <= inj_index;
            armed_q <= 1'b0;
         end else begin
            if (inj_arm) armed_q <= 1'b1;
            if (advance && hit) begin
               pend_q     <= 1'b0;
               inj_done_q <= 1'b1;
            end
         end
      end
   end
`else
   assign inj_mask = '0;
`endif

   assign busy       = (state_q == ST_RUN);
   assign dout_valid = busy;
   assign dout       = busy ? (word ^ inj_mask) : '0;
   assign done       = done_q;

endmodule
